// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry record, forward-select encoding and select-width helper.
package hazard_pkg;
    // Destination field sized for any legal register address width up to 8 bits.
    localparam int DST_W  = 8;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic             load;
    } entry_t;
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/hazard_scoreboard_youngest_match.sv
// youngest_match: priority finder returning the youngest scoreboard entry that writes src,
// its stage index and the stage at which its result becomes forwardable.
module youngest_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = sel_w(DEPTH)
) (
    input  entry_t [DEPTH-1:0] ent,
    input  logic [DST_W-1:0]   src,
    input  logic               use_src,
    input  logic [DEPTH-1:0]   mask,
    output logic               hit,
    output logic [SEL_W-1:0]   idx,
    output logic [SEL_W-1:0]   rdy
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        rdy = '0;
        // Scan oldest to youngest so the youngest hit overwrites older ones.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_src && mask[k] && ent[k].valid && (ent[k].dst == src)) begin
                hit = 1'b1;
                idx = SEL_W'(k);
                rdy = ent[k].load ? SEL_W'(LOAD_RDY) : SEL_W'(1);
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard-based stall, flush and forwarding-select unit for an in-order MIPS pipeline.
// Define HAZARD_PERF_EN to add saturating perf_stall_cycles / perf_flushes counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = sel_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_is_branch,
    input  logic              id_branch_taken,
    input  logic              id_jump,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_flush,
    output logic              if_flush,
    output logic [SEL_W-1:0]  fwd_a_id,
    output logic [SEL_W-1:0]  fwd_b_id,
    output logic [SEL_W-1:0]  fwd_a_ex,
    output logic [SEL_W-1:0]  fwd_b_ex
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes
`endif
);
    localparam logic [DEPTH-1:0] ID_MASK = '1;
    // The EX instruction itself sits in s[0]; only older entries can feed it.
    localparam logic [DEPTH-1:0] EX_MASK = {{(DEPTH-1){1'b1}}, 1'b0};

    entry_t [DEPTH-1:0] s_q, s_d;
    entry_t             s0;
    logic [REG_AW-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic               ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
    logic [DST_W-1:0]   src [4];
    logic [3:0]         use_src, hit;
    logic [SEL_W-1:0]   idx [4];
    logic [SEL_W-1:0]   rdy [4];
    logic               ex_haz, br_haz, stall;

    always_comb begin
        src[0]  = DST_W'(id_rs);
        src[1]  = DST_W'(id_rt);
        src[2]  = DST_W'(ex_rs_q);
        src[3]  = DST_W'(ex_rt_q);
        use_src = {ex_use_rt_q, ex_use_rs_q, id_use_rt, id_use_rs};
    end

    for (genvar i = 0; i < 4; i++) begin : g_m
        youngest_match #(.DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)) u_m (
            .ent     (s_q),
            .src     (src[i]),
            .use_src (use_src[i]),
            .mask    (i < 2 ? ID_MASK : EX_MASK),
            .hit     (hit[i]),
            .idx     (idx[i]),
            .rdy     (rdy[i])
        );
    end

    always_comb begin
        ex_haz      = (hit[0] && (idx[0] + SEL_W'(1) < rdy[0])) || (hit[1] && (idx[1] + SEL_W'(1) < rdy[1]));
        br_haz      = id_is_branch && ((hit[0] && (idx[0] < rdy[0])) || (hit[1] && (idx[1] < rdy[1])));
        stall       = id_valid && (ex_haz || br_haz);
        pc_hold     = stall;
        if_id_hold  = stall;
        id_ex_flush = stall;
        if_flush    = id_valid && !stall && (id_jump || (id_is_branch && id_branch_taken));
        fwd_a_id    = (hit[0] && !br_haz) ? idx[0] + SEL_W'(1) : SEL_W'(FWD_RF);
        fwd_b_id    = (hit[1] && !br_haz) ? idx[1] + SEL_W'(1) : SEL_W'(FWD_RF);
        fwd_a_ex    = hit[2] ? idx[2] : SEL_W'(FWD_RF);
        fwd_b_ex    = hit[3] ? idx[3] : SEL_W'(FWD_RF);
        s0          = '{valid: id_valid && id_reg_write && (id_rd != '0), dst: DST_W'(id_rd), load: id_mem_read};
        if (stall) s0 = '0;
        s_d         = {s_q[DEPTH-2:0], s0};
        ex_rs_d     = stall ? '0 : id_rs;
        ex_rt_d     = stall ? '0 : id_rt;
        ex_use_rs_d = !stall && id_valid && id_use_rs;
        ex_use_rt_d = !stall && id_valid && id_use_rt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q         <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_use_rs_q <= ex_use_rs_d;
            ex_use_rt_q <= ex_use_rt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stall && (perf_stall_q != '1));
        perf_flush_d = perf_flush_q + 32'(if_flush && (perf_flush_q != '1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized instruction streams checked against a
// history-based hazard model through an expected-response queue.
module tb_hazard_scoreboard;
    localparam int REG_AW   = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 2;
    localparam int SEL_W    = $clog2(DEPTH + 1);

    typedef struct { bit v, urs, urt, wr, ld, br, tk, j; int rs, rt, rd, cyc; } instr_t;
    typedef struct { int stall, flush, fa_id, fb_id, fa_ex, fb_ex, pst, pfl; } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_reg_write = 1'b0;
    logic id_mem_read = 1'b0, id_is_branch = 1'b0, id_branch_taken = 1'b0, id_jump = 1'b0;
    logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic pc_hold, if_id_hold, id_ex_flush, if_flush;
    logic [SEL_W-1:0] fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flushes;
`endif

    int checks = 0;
    int errors = 0;
    int cur = 0;
    int pst = 0;
    int pfl = 0;
    exp_t q[$];
    instr_t hist[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump), .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_flush(id_ex_flush),
        .if_flush(if_flush), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id), .fwd_a_ex(fwd_a_ex),
        .fwd_b_ex(fwd_b_ex)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
    );

    function automatic void chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cur, act, exp);
        end
    endfunction

    // Youngest in-flight writer of register r whose age (stages past ID minus one) is in [amin, DEPTH-1].
    function automatic void find(input int r, input int amin, output bit f, output int age, output bit ld);
        f = 0;
        age = 0;
        ld = 0;
        for (int n = hist.size() - 1; n >= 0; n--) begin
            int a;
            a = cur - hist[n].cyc - 1;
            if (!f && a >= amin && a < DEPTH && hist[n].wr && hist[n].rd != 0 && hist[n].rd == r) begin
                f = 1;
                age = a;
                ld = hist[n].ld;
            end
        end
    endfunction

    function automatic instr_t ins(int rd, bit wr, bit ld, int rs, bit urs, int rt, bit urt, bit br, bit tk, bit j);
        instr_t i;
        i = '{v: 1, urs: urs, urt: urt, wr: wr, ld: ld, br: br, tk: tk, j: j, rs: rs, rt: rt, rd: rd, cyc: 0};
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        int k;
        k = $urandom_range(0, 99);
        i = ins($urandom_range(0, 7), 0, k < 25, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0, k >= 25 && k < 45, 0, k >= 45 && k < 55);
        i.v = $urandom_range(0, 9) != 0;
        i.wr = (k < 25) || (k >= 55 && $urandom_range(0, 6) != 0);
        i.tk = i.br && ($urandom_range(0, 1) == 1);
        if (i.br) begin
            i.urs = 1;
            i.urt = 1;
        end
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit rst, output bit st, output bit fl);
        exp_t e;
        bit fa, fb, la, lb, xa, xb, xl, brh, exh;
        int ka, kb, ra, rb, xka, xkb;
        reset = rst;
        id_valid = i.v;
        id_rs = REG_AW'(i.rs);
        id_rt = REG_AW'(i.rt);
        id_rd = REG_AW'(i.rd);
        id_use_rs = i.urs;
        id_use_rt = i.urt;
        id_reg_write = i.wr;
        id_mem_read = i.ld;
        id_is_branch = i.br;
        id_branch_taken = i.tk;
        id_jump = i.j;
        find(i.rs, 0, fa, ka, la);
        find(i.rt, 0, fb, kb, lb);
        fa &= i.urs;
        fb &= i.urt;
        ra = la ? LOAD_RDY : 1;
        rb = lb ? LOAD_RDY : 1;
        exh = (fa && ka + 1 < ra) || (fb && kb + 1 < rb);
        brh = i.br && ((fa && ka < ra) || (fb && kb < rb));
        st = i.v && (exh || brh);
        fl = i.v && !st && (i.j || (i.br && i.tk));
        e.stall = st;
        e.flush = fl;
        e.fa_id = (fa && !brh) ? ka + 1 : 0;
        e.fb_id = (fb && !brh) ? kb + 1 : 0;
        e.fa_ex = 0;
        e.fb_ex = 0;
        if (hist.size() > 0 && hist[$].cyc == cur - 1) begin
            find(hist[$].rs, 1, xa, xka, xl);
            find(hist[$].rt, 1, xb, xkb, xl);
            e.fa_ex = (xa && hist[$].urs) ? xka : 0;
            e.fb_ex = (xb && hist[$].urt) ? xkb : 0;
        end
        e.pst = pst;
        e.pfl = pfl;
        q.push_back(e);
        if (rst) begin
            hist.delete();
            pst = 0;
            pfl = 0;
        end else begin
            if (i.v && !st) begin
                i.cyc = cur;
                hist.push_back(i);
            end
            pst += int'(st);
            pfl += int'(fl);
            while (hist.size() > 0 && cur - hist[0].cyc > DEPTH + 1) void'(hist.pop_front());
        end
        cur++;
        @(posedge clock);
        #1;
    endtask

    task automatic exec(input instr_t i, input int exp_stalls, input string n);
        bit st, fl;
        int k;
        k = 0;
        drive(i, 0, st, fl);
        while (st && k < 8) begin
            k++;
            drive(i, 0, st, fl);
        end
        chk(n, k, exp_stalls);
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("pc_hold", int'(pc_hold), mon_e.stall);
            chk("if_id_hold", int'(if_id_hold), mon_e.stall);
            chk("id_ex_flush", int'(id_ex_flush), mon_e.stall);
            chk("if_flush", int'(if_flush), mon_e.flush);
            chk("fwd_a_id", int'(fwd_a_id), mon_e.fa_id);
            chk("fwd_b_id", int'(fwd_b_id), mon_e.fb_id);
            chk("fwd_a_ex", int'(fwd_a_ex), mon_e.fa_ex);
            chk("fwd_b_ex", int'(fwd_b_ex), mon_e.fb_ex);
`ifdef HAZARD_PERF_EN
            chk("perf_stall_cycles", int'(perf_stall_cycles), mon_e.pst);
            chk("perf_flushes", int'(perf_flushes), mon_e.pfl);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t nop, lw2, cur_i;
        bit st, fl;
        nop = '{default: 0};
        lw2 = ins(2, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        repeat (DEPTH + 1) exec(nop, 0, "idle_after_reset");
        exec(lw2, 0, "lw");
        exec(ins(3, 1, 0, 2, 1, 4, 1, 0, 0, 0), LOAD_RDY - 1, "load_use_stalls");
        repeat (DEPTH + 1) exec(nop, 0, "drain");
        exec(ins(2, 1, 0, 1, 1, 1, 1, 0, 0, 0), 0, "alu");
        exec(ins(0, 0, 0, 2, 1, 5, 1, 1, 1, 0), 1, "alu_branch_stalls");
        repeat (DEPTH + 1) exec(nop, 0, "drain");
        exec(lw2, 0, "lw");
        exec(ins(0, 0, 0, 2, 1, 0, 1, 1, 1, 0), LOAD_RDY, "load_branch_stalls");
        repeat (DEPTH + 1) exec(nop, 0, "drain");
        exec(ins(2, 1, 0, 1, 1, 1, 1, 0, 0, 0), 0, "alu_a");
        exec(ins(2, 1, 0, 1, 1, 1, 1, 0, 0, 0), 0, "alu_b");
        exec(ins(6, 1, 0, 2, 1, 2, 1, 0, 0, 0), 0, "youngest_wins");
        exec(nop, 0, "nop");
        exec(ins(0, 1, 0, 1, 1, 1, 1, 0, 0, 0), 0, "write_r0");
        exec(ins(3, 1, 0, 0, 1, 0, 1, 0, 0, 0), 0, "r0_no_stall");
        repeat (DEPTH + 1) exec(nop, 0, "drain");
        exec(lw2, 0, "lw");
        exec(ins(0, 0, 0, 2, 1, 0, 0, 0, 0, 1), LOAD_RDY - 1, "jump_stalls");
        exec(nop, 0, "after_flush");
        exec(lw2, 0, "lw");
        drive(ins(3, 1, 0, 2, 1, 4, 1, 0, 0, 0), 1, st, fl);
        exec(ins(3, 1, 0, 2, 1, 4, 1, 0, 0, 0), 0, "post_reset_stalls");
        st = 0;
        fl = 0;
        cur_i = nop;
        repeat (3000) begin
            if (!st) cur_i = fl ? nop : rnd();
            drive(cur_i, $urandom_range(0, 299) == 0, st, fl);
        end
        drive(nop, 0, st, fl);
        chk("queue_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard detection and forwarding-select unit for the in-order MIPS pipeline, replacing the fixed two-stage load-use and branch logic in the ID stage. It keeps a shift-register scoreboard of in-flight destination registers for every stage after ID, from EX up to and including WB. From that scoreboard it generates the stall, flush and forwarding-mux selects for both the ID-stage branch comparator and the EX-stage ALU operands. Pipeline depth and load latency are parameters, so the same block serves deeper memory stages.

## Interface
Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID; s[0]=EX … s[DEPTH-1]=WB; legal range 2..7.
- LOAD_RDY, 2, first stage index whose pipeline register holds load data; legal range 1..DEPTH-1.
- SEL_W, $clog2(DEPTH+1), forward-select width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_use_rs, id_use_rt  in  1  source is actually read.
- id_rd  in  REG_AW  destination after RegDst selection.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_mem_read  in  1  ID instruction is a load.
- id_is_branch  in  1  beq/bne compared in ID.
- id_branch_taken  in  1  comparator result, qualified by id_is_branch.
- id_jump  in  1  jump in ID.
- pc_hold, if_id_hold, id_ex_flush  out  1  stall controls.
- if_flush  out  1  squash IF/ID.
- fwd_a_id, fwd_b_id  out  SEL_W  branch comparator operand selects.
- fwd_a_ex, fwd_b_ex  out  SEL_W  ALU operand selects.

## Operation
- Entry per stage: valid, dst, load. Writes to register 0 are never recorded (valid=0).
- Advance every cycle: s[k] <= s[k-1] for k≥1.
- When `stall`=0, s[0] <= {id_valid&id_reg_write&(id_rd!=0), id_rd, id_mem_read}. When `stall`=1, s[0] <= bubble.
- Ready stage of an entry: 1 for an ALU result, LOAD_RDY for a load.
- Match: s[k].valid and s[k].dst equals the source register, with the matching use flag set. The youngest match (smallest k) decides.
- EX hazard: the ID source's youngest match at k satisfies k+1 < ready.
- Branch hazard: id_is_branch and the youngest match satisfies k < ready.
- `stall` = id_valid & (EX hazard | branch hazard). pc_hold = if_id_hold = id_ex_flush = stall.
- if_flush = id_valid & ~stall & (id_jump | (id_is_branch & id_branch_taken)). A stalled branch never flushes.
- fwd_*_id: 0 selects the register file; k+1 selects s[k]'s stage output. It is driven only when no branch hazard exists; otherwise it is 0.
- fwd_*_ex: the EX instruction's rs/rt/use flags are registered when `stall`=0 and cleared on a bubble. Select = youngest match among s[1..DEPTH-1] → k. With no match the select is 0.
- WB write-through is handled by the register file. Entries leave the scoreboard after s[DEPTH-1].

## Timing
- Scoreboard, registered EX sources and counters update on clock edges. All outputs are combinational from registers and the ID inputs, with zero-cycle latency.
- Reset, at any point including mid-stall: all entries invalid, EX sources cleared, counters 0.
- The cycle after reset, every output is 0 unless a branch or jump is already in ID.
- Load-use with default parameters gives exactly one stall cycle. ALU→branch gives one stall cycle. Load→branch gives two.
- Stall and taken branch in the same cycle: the stall wins and if_flush asserts on the release cycle.

## Configuration
- HAZARD_PERF_EN defined: adds outputs perf_stall_cycles and perf_flushes, both 32-bit.
  - They increment on each `stall` cycle and each if_flush cycle.
  - They saturate at 0xFFFFFFFF.
  - They reset to 0.
- HAZARD_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - the entry record (valid/dst/load);
  - the select encoding constants (FWD_RF=0);
  - the SEL_W computation.
- One sub-module, youngest_match: combinational priority finder over the DEPTH entries, returning hit, index and ready. It is instantiated four times (ID a/b, EX a/b).

## Test plan
- lw $2 then add $3,$2,$4 → stall=1 for one cycle, bubble in s[0]; next cycle fwd_a_ex=2 (s[1]=MEM).
- add $2 then beq $2,$5 → one stall cycle; then fwd_a_id=2 and if_flush=1 when taken.
- lw $2 then beq $2,$0 → stall for 2 cycles; release shows fwd_a_id=3 (WB).
- add $2; add $2; sub $6,$2,$2 → fwd_a_ex=fwd_b_ex=1 (youngest wins); add $0 producer → no forward and no stall.
- j during a stall → if_flush=0 until stall drops, then exactly one cycle of 1; reset asserted mid-stall → all outputs 0 next cycle.
- DEPTH=4, LOAD_RDY=3, lw→add → two stall cycles; with HAZARD_PERF_EN, perf_stall_cycles=2.
